// File: rtl/cpu_pkg.sv
// Shared definitions for the MIPS core's hazard and forwarding logic.
package cpu_pkg;

  // Architectural register address width and the hardwired-zero register.
  localparam int REG_ADDR_W = 5;
  localparam logic [REG_ADDR_W-1:0] REG_ZERO = '0;

  // Forwarding-select encoding for the EX operand muxes.
  localparam int FWD_RF  = 0;  // register file
  localparam int FWD_EX  = 1;  // EX output (entry 0)
  localparam int FWD_MEM = 2;  // MEM output (entry 1)
  localparam int FWD_WB  = 3;  // WB output (entry 2)

  // Readiness countdown width; LOAD_LAT-1 must fit.
  localparam int LAT_W = 4;

  // One in-flight producer: destination register and cycles until forwardable.
  typedef struct packed {
    logic                  valid;
    logic [REG_ADDR_W-1:0] dst;
    logic [LAT_W-1:0]      cnt;
  } sb_entry_t;

endpackage

// File: rtl/hazard_match.sv
// Youngest-match priority encoder: finds the lowest-index valid entry whose
// destination equals the requested source register.
module hazard_match
  import cpu_pkg::*;
#(
  parameter int DEPTH = 3,
  parameter int SEL_W = $clog2(DEPTH + 1)
) (
  input  logic                  req_i,
  input  logic [REG_ADDR_W-1:0] addr_i,
  input  sb_entry_t             entries_i [DEPTH],
  output logic                  hit_o,
  output logic [SEL_W-1:0]      index_o,
  output logic                  not_ready_o
);

  // Scan oldest to youngest so the youngest match overwrites older ones.
  always_comb begin
    hit_o       = 1'b0;
    index_o     = '0;
    not_ready_o = 1'b0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (req_i && entries_i[i].valid && (entries_i[i].dst == addr_i)) begin
        hit_o       = 1'b1;
        index_o     = SEL_W'(i);
        not_ready_o = (entries_i[i].cnt != '0);
      end
    end
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// ID-stage hazard scoreboard: tracks in-flight destinations in a shift
// pipeline mirroring EX..WB, stalls on not-yet-ready producers and drives
// per-operand forwarding selects. REG_ADDR_W must match cpu_pkg.
module hazard_scoreboard
  import cpu_pkg::*;
#(
  parameter int REG_ADDR_W = cpu_pkg::REG_ADDR_W,
  parameter int DEPTH      = 3,
  parameter int ALU_LAT    = 1,
  parameter int LOAD_LAT   = 2,
  parameter int CNT_W      = 32,
  parameter int SEL_W      = $clog2(DEPTH + 1)
) (
  input  logic                  clock,
  input  logic                  start,
  input  logic                  issue_valid,
  input  logic [REG_ADDR_W-1:0] rs_addr,
  input  logic                  rs_used,
  input  logic [REG_ADDR_W-1:0] rt_addr,
  input  logic                  rt_used,
  input  logic [REG_ADDR_W-1:0] rd_addr,
  input  logic                  rd_we,
  input  logic                  is_load,
  input  logic                  flush,
  output logic                  stall,
  output logic [SEL_W-1:0]      fwd_sel_a,
  output logic [SEL_W-1:0]      fwd_sel_b,
  output logic                  busy,
  output logic [CNT_W-1:0]      stall_count
);

  sb_entry_t         entry_q [DEPTH];
  sb_entry_t         entry_d [DEPTH];
  logic [CNT_W-1:0]  stall_count_q, stall_count_d;

  logic              a_req, a_hit, a_not_ready;
  logic              b_req, b_hit, b_not_ready;
  logic [SEL_W-1:0]  a_index, b_index;
  logic              issue_ok;

  // A source only looks for producers when it is actually read and non-zero.
  assign a_req = issue_valid & rs_used & (rs_addr != REG_ZERO);
  assign b_req = issue_valid & rt_used & (rt_addr != REG_ZERO);

  hazard_match #(.DEPTH(DEPTH), .SEL_W(SEL_W)) u_match_a (
    .req_i       (a_req),
    .addr_i      (rs_addr),
    .entries_i   (entry_q),
    .hit_o       (a_hit),
    .index_o     (a_index),
    .not_ready_o (a_not_ready)
  );

  hazard_match #(.DEPTH(DEPTH), .SEL_W(SEL_W)) u_match_b (
    .req_i       (b_req),
    .addr_i      (rt_addr),
    .entries_i   (entry_q),
    .hit_o       (b_hit),
    .index_o     (b_index),
    .not_ready_o (b_not_ready)
  );

  // Flush wins over stall: a squashed instruction never waits.
  assign stall     = issue_valid & ~flush & ((a_hit & a_not_ready) | (b_hit & b_not_ready));
  assign fwd_sel_a = a_hit ? a_index + SEL_W'(FWD_EX) : SEL_W'(FWD_RF);
  assign fwd_sel_b = b_hit ? b_index + SEL_W'(FWD_EX) : SEL_W'(FWD_RF);

  // Only register-writing, non-zero-destination instructions that really issue enter the pipe.
  assign issue_ok  = issue_valid & ~stall & ~flush & rd_we & (rd_addr != REG_ZERO);

  // Busy whenever any stage still holds a producer.
  always_comb begin
    busy = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      busy = busy | entry_q[i].valid;
    end
  end

  // Next pipeline contents: new issue or bubble at entry 0, older entries shift with countdown.
  always_comb begin
    entry_d[0] = '0;
    if (issue_ok) begin
      entry_d[0].valid = 1'b1;
      entry_d[0].dst   = rd_addr;
      entry_d[0].cnt   = is_load ? LAT_W'(LOAD_LAT - 1) : LAT_W'(ALU_LAT - 1);
    end
    for (int i = 1; i < DEPTH; i++) begin
      entry_d[i] = entry_q[i-1];
      if (entry_q[i-1].cnt != '0) begin
        entry_d[i].cnt = entry_q[i-1].cnt - LAT_W'(1);
      end
    end
  end

  // Saturating count of stalled cycles.
  always_comb begin
    stall_count_d = stall_count_q;
    if (stall && (stall_count_q != '1)) begin
      stall_count_d = stall_count_q + CNT_W'(1);
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!start) begin
      for (int i = 0; i < DEPTH; i++) begin
        entry_q[i] <= '0;
      end
      stall_count_q <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        entry_q[i] <= entry_d[i];
      end
      stall_count_q <= stall_count_d;
    end
  end

  assign stall_count = stall_count_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench for hazard_scoreboard: directed scenarios plus a
// randomized run against an issue-history reference model.
module tb_hazard_scoreboard;

  localparam int DEPTH    = 3;
  localparam int ALU_LAT  = 1;
  localparam int LOAD_LAT = 2;
  localparam int SEL_W    = $clog2(DEPTH + 1);

  logic              clock;
  logic              start;
  logic              issue_valid;
  logic [4:0]        rs_addr, rt_addr, rd_addr;
  logic              rs_used, rt_used, rd_we, is_load, flush;
  logic              stall, busy;
  logic [SEL_W-1:0]  fwd_sel_a, fwd_sel_b;
  logic [31:0]       stall_count;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: history of accepted producers (issue cycle, dst, latency).
  int cyc = 0;
  int q_s[$];
  int q_d[$];
  int q_l[$];
  int exp_cnt = 0;

  hazard_scoreboard #(
    .REG_ADDR_W(5), .DEPTH(DEPTH), .ALU_LAT(ALU_LAT), .LOAD_LAT(LOAD_LAT), .CNT_W(32)
  ) dut (
    .clock(clock), .start(start), .issue_valid(issue_valid),
    .rs_addr(rs_addr), .rs_used(rs_used), .rt_addr(rt_addr), .rt_used(rt_used),
    .rd_addr(rd_addr), .rd_we(rd_we), .is_load(is_load), .flush(flush),
    .stall(stall), .fwd_sel_a(fwd_sel_a), .fwd_sel_b(fwd_sel_b),
    .busy(busy), .stall_count(stall_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Youngest producer of addr issued 1..DEPTH cycles ago; ready once age >= latency.
  function automatic void eval_op(input bit used, input int addr, output int sel, output bit nr);
    int best;
    best = DEPTH + 1;
    sel  = 0;
    nr   = 1'b0;
    for (int k = 0; k < q_s.size(); k++) begin
      int age;
      age = cyc - q_s[k];
      if (issue_valid && used && addr != 0 && age >= 1 && age <= DEPTH &&
          q_d[k] == addr && age < best) begin
        best = age;
        sel  = age;
        nr   = (age < q_l[k]);
      end
    end
  endfunction

  function automatic void model(output bit st, output int sa, output int sb, output bit by);
    bit na, nb;
    eval_op(rs_used, int'(rs_addr), sa, na);
    eval_op(rt_used, int'(rt_addr), sb, nb);
    st = issue_valid && !flush && (na || nb);
    by = 1'b0;
    for (int k = 0; k < q_s.size(); k++) begin
      if ((cyc - q_s[k]) >= 1 && (cyc - q_s[k]) <= DEPTH) by = 1'b1;
    end
  endfunction

  task automatic set_instr(input bit iv, input int rs, input bit ru, input int rt, input bit rtu,
                           input int rd, input bit we, input bit ld, input bit fl);
    issue_valid = iv;
    rs_addr = 5'(rs); rs_used = ru;
    rt_addr = 5'(rt); rt_used = rtu;
    rd_addr = 5'(rd); rd_we = we;
    is_load = ld; flush = fl;
    #1;
  endtask

  task automatic idle();
    set_instr(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Advance one clock, updating the model from its own stall prediction.
  task automatic tick();
    bit st, by;
    int sa, sb;
    model(st, sa, sb, by);
    $display("txn cyc=%0d start=%0d iv=%0d rs=%0d/%0d rt=%0d/%0d rd=%0d/%0d ld=%0d fl=%0d -> stall=%0d sel_a=%0d sel_b=%0d busy=%0d cnt=%0d",
             cyc, start, issue_valid, rs_addr, rs_used, rt_addr, rt_used, rd_addr, rd_we,
             is_load, flush, stall, fwd_sel_a, fwd_sel_b, busy, stall_count);
    if (!start) begin
      q_s.delete(); q_d.delete(); q_l.delete();
      exp_cnt = 0;
    end else begin
      if (st) exp_cnt++;
      if (issue_valid && !st && !flush && rd_we && rd_addr != 0) begin
        q_s.push_back(cyc);
        q_d.push_back(int'(rd_addr));
        q_l.push_back(is_load ? LOAD_LAT : ALU_LAT);
      end
    end
    @(posedge clock);
    cyc++;
    while (q_s.size() > 0 && (cyc - q_s[0]) > DEPTH) begin
      void'(q_s.pop_front()); void'(q_d.pop_front()); void'(q_l.pop_front());
    end
    @(negedge clock);
  endtask

  task automatic drain();
    idle();
    for (int i = 0; i < DEPTH + 1; i++) tick();
  endtask

  task automatic test_reset();
    start = 1'b0;
    idle();
    tick();
    tick();
    start = 1'b1;
    idle();
    n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall got=%0d want=0", stall); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%0d want=0", busy); end
    n_checks++; if (fwd_sel_a !== '0 || fwd_sel_b !== '0) begin n_fail++; $display("FAIL reset_sel got=%0d/%0d want=0/0", fwd_sel_a, fwd_sel_b); end
    n_checks++; if (stall_count !== 32'd0) begin n_fail++; $display("FAIL reset_count got=%0d want=0", stall_count); end
  endtask

  task automatic test_load_use();
    drain();
    set_instr(1, 4, 1, 0, 0, 1, 1, 1, 0);   // lw gr1
    tick();
    set_instr(1, 1, 1, 2, 1, 3, 1, 0, 0);   // add gr3 = gr1 + gr2
    n_checks++; if (stall !== 1'b1) begin n_fail++; $display("FAIL loaduse_stall got=%0d want=1", stall); end
    tick();
    n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL loaduse_release got=%0d want=0", stall); end
    n_checks++; if (fwd_sel_a !== 2'd2 || fwd_sel_b !== 2'd0) begin n_fail++; $display("FAIL loaduse_sel got=%0d/%0d want=2/0", fwd_sel_a, fwd_sel_b); end
    n_checks++; if (stall_count !== 32'd1) begin n_fail++; $display("FAIL loaduse_count got=%0d want=1", stall_count); end
    tick();
  endtask

  task automatic test_back_to_back();
    drain();
    set_instr(1, 1, 1, 2, 1, 3, 1, 0, 0);   // add gr3
    tick();
    set_instr(1, 3, 1, 3, 1, 4, 1, 0, 0);   // sub gr4 = gr3 - gr3
    n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL b2b_stall got=%0d want=0", stall); end
    n_checks++; if (fwd_sel_a !== 2'd1 || fwd_sel_b !== 2'd1) begin n_fail++; $display("FAIL b2b_sel got=%0d/%0d want=1/1", fwd_sel_a, fwd_sel_b); end
    tick();
  endtask

  task automatic test_distance();
    for (int d = 2; d <= 4; d++) begin
      int want;
      want = (d <= DEPTH) ? d : 0;
      drain();
      set_instr(1, 1, 1, 2, 1, 3, 1, 0, 0);
      tick();
      idle();
      for (int k = 1; k < d; k++) tick();
      set_instr(1, 3, 1, 0, 0, 5, 1, 0, 0);
      n_checks++; if (int'(fwd_sel_a) != want || stall !== 1'b0) begin n_fail++; $display("FAIL distance_%0d got=%0d stall=%0d want=%0d stall=0", d, fwd_sel_a, stall, want); end
      tick();
    end
    drain();
    set_instr(1, 1, 1, 0, 0, 3, 1, 0, 0);
    tick();
    set_instr(1, 2, 1, 0, 0, 3, 1, 0, 0);
    tick();
    set_instr(1, 0, 0, 3, 1, 6, 1, 0, 0);
    n_checks++; if (fwd_sel_b !== 2'd1) begin n_fail++; $display("FAIL youngest_wins got=%0d want=1", fwd_sel_b); end
    tick();
  endtask

  task automatic test_gr0_flush();
    drain();
    set_instr(1, 1, 1, 0, 0, 0, 1, 0, 0);   // addi gr0
    tick();
    set_instr(1, 0, 1, 0, 1, 4, 1, 0, 0);
    n_checks++; if (fwd_sel_a !== '0 || fwd_sel_b !== '0 || stall !== 1'b0) begin n_fail++; $display("FAIL gr0 got sel=%0d/%0d stall=%0d want 0/0 stall=0", fwd_sel_a, fwd_sel_b, stall); end
    tick();
    drain();
    set_instr(1, 4, 1, 0, 0, 1, 1, 1, 1);   // lw gr1, flushed
    n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL flush_stall got=%0d want=0", stall); end
    tick();
    set_instr(1, 1, 1, 1, 1, 5, 1, 0, 0);
    n_checks++; if (stall !== 1'b0 || fwd_sel_a !== '0 || busy !== 1'b0) begin n_fail++; $display("FAIL flush_drop got stall=%0d sel=%0d busy=%0d want 0/0/0", stall, fwd_sel_a, busy); end
    tick();
  endtask

  task automatic test_reset_mid_stall();
    drain();
    set_instr(1, 4, 1, 0, 0, 1, 1, 1, 0);   // lw gr1
    tick();
    set_instr(1, 1, 1, 0, 0, 3, 1, 0, 0);
    n_checks++; if (stall !== 1'b1) begin n_fail++; $display("FAIL midstall_pre got=%0d want=1", stall); end
    start = 1'b0;
    tick();
    start = 1'b1;
    #1;
    n_checks++; if (stall !== 1'b0 || busy !== 1'b0 || stall_count !== 32'd0) begin n_fail++; $display("FAIL midstall_reset got stall=%0d busy=%0d cnt=%0d want 0/0/0", stall, busy, stall_count); end
    n_checks++; if (fwd_sel_a !== '0) begin n_fail++; $display("FAIL midstall_sel got=%0d want=0", fwd_sel_a); end
    tick();
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      bit st, by;
      int sa, sb;
      start = ($urandom_range(0, 49) != 0);
      set_instr($urandom_range(0, 3) != 0, $urandom_range(0, 3), $urandom_range(0, 1),
                $urandom_range(0, 3), $urandom_range(0, 1), $urandom_range(0, 3),
                $urandom_range(0, 4) != 0, $urandom_range(0, 2) == 0, $urandom_range(0, 9) == 0);
      model(st, sa, sb, by);
      n_checks++;
      if (stall !== st || int'(fwd_sel_a) != sa || int'(fwd_sel_b) != sb || busy !== by ||
          stall_count !== 32'(exp_cnt)) begin
        n_fail++;
        $display("FAIL random_%0d got stall=%0d sel=%0d/%0d busy=%0d cnt=%0d want stall=%0d sel=%0d/%0d busy=%0d cnt=%0d",
                 n, stall, fwd_sel_a, fwd_sel_b, busy, stall_count, st, sa, sb, by, exp_cnt);
      end
      tick();
    end
    start = 1'b1;
  endtask

  initial begin
    start = 1'b0;
    idle();
    test_reset();
    test_load_use();
    test_back_to_back();
    test_distance();
    test_gr0_flush();
    test_reset_mid_stall();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
